// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (busy) bits for write-after-write hazard tracking.
// Two combinational read ports with optional write forwarding, one write port, one claim port.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_claimEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_claimReg,
    output logic                  busy_A,
    output logic                  busy_B,
    output logic                  claim_reject,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [ADDR_WIDTH:0]   countQ;
    logic [ADDR_WIDTH:0]   countNext;

    logic writePresented;
    logic writeAccept;
    logic claimValid;
    logic claimRejectInt;
    logic claimAccept;
    logic countInc;
    logic countDec;
    logic bypassA;
    logic bypassB;

    // A write to the claimed register in the same cycle retires the old producer,
    // so the claim is allowed even though the busy bit is still set.
    always_comb begin
        writePresented = ctrl_writeEnable && (ctrl_writeReg != '0);
        writeAccept    = writePresented && ctrl_reset;
        claimValid     = ctrl_claimEnable && (ctrl_claimReg != '0);
        claimRejectInt = claimValid && busy[ctrl_claimReg]
                         && !(writePresented && (ctrl_writeReg == ctrl_claimReg));
        claimAccept    = claimValid && !claimRejectInt;
        countInc       = claimAccept && !busy[ctrl_claimReg];
        countDec       = writeAccept && busy[ctrl_writeReg]
                         && !(claimAccept && (ctrl_claimReg == ctrl_writeReg));
    end

    always_comb begin
        countNext = countQ;
        if (countInc && !countDec && (countQ != CNT_MAX)) begin
            countNext = countQ + CNT_ONE;
        end else if (countDec && !countInc && (countQ != '0)) begin
            countNext = countQ - CNT_ONE;
        end
    end

    // Forwarding only applies to writes that will actually land, so reads during reset show stored data.
    always_comb begin
        bypassA = (BYPASS != 0) && writeAccept && (ctrl_writeReg == ctrl_readRegA);
        bypassB = (BYPASS != 0) && writeAccept && (ctrl_writeReg == ctrl_readRegB);

        data_readRegA = '0;
        data_readRegB = '0;
        if (ctrl_readRegA != '0) begin
            data_readRegA = bypassA ? data_writeReg : regs[ctrl_readRegA];
        end
        if (ctrl_readRegB != '0) begin
            data_readRegB = bypassB ? data_writeReg : regs[ctrl_readRegB];
        end

        busy_A       = (ctrl_readRegA != '0) && busy[ctrl_readRegA] && !bypassA;
        busy_B       = (ctrl_readRegB != '0) && busy[ctrl_readRegB] && !bypassB;
        claim_reject = claimRejectInt;
        busy_count   = countQ;
    end

    // The claim update follows the write clear so a same-register claim wins.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy   <= '0;
            countQ <= '0;
        end else begin
            if (writeAccept) begin
                regs[ctrl_writeReg] <= data_writeReg;
                busy[ctrl_writeReg] <= 1'b0;
            end
            if (claimAccept) begin
                busy[ctrl_claimReg] <= 1'b1;
            end
            countQ <= countNext;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a forwarding and a non-forwarding instance share stimulus
// and are checked against a behavioural model of data, busy bits and pending count.
module tb_regfile_scoreboard;

    typedef struct {
        logic [31:0] dA;
        logic [31:0] dB;
        logic [31:0] nA;
        logic [31:0] nB;
        logic        bA;
        logic        bB;
        logic        nbA;
        logic        nbB;
        logic        rej;
        logic [5:0]  cnt;
    } expT;

    logic        clock = 1'b0;
    logic        ctrlReset;
    logic        writeEnable;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readRegA;
    logic [4:0]  readRegB;
    logic        claimEnable;
    logic [4:0]  claimReg;

    logic [31:0] dataA, dataB, nbDataA, nbDataB;
    logic        busyA, busyB, nbBusyA, nbBusyB, reject, nbReject;
    logic [5:0]  busyCount, nbBusyCount;

    logic [31:0] mRegs [32];
    logic        mBusy [32];
    expT         expQ [$];
    int          checkCount = 0;
    int          errorCount = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
        .clock(clock), .ctrl_reset(ctrlReset),
        .ctrl_writeEnable(writeEnable), .ctrl_writeReg(writeReg), .data_writeReg(writeData),
        .ctrl_readRegA(readRegA), .ctrl_readRegB(readRegB),
        .data_readRegA(dataA), .data_readRegB(dataB),
        .ctrl_claimEnable(claimEnable), .ctrl_claimReg(claimReg),
        .busy_A(busyA), .busy_B(busyB), .claim_reject(reject), .busy_count(busyCount)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dutNoBypass (
        .clock(clock), .ctrl_reset(ctrlReset),
        .ctrl_writeEnable(writeEnable), .ctrl_writeReg(writeReg), .data_writeReg(writeData),
        .ctrl_readRegA(readRegA), .ctrl_readRegB(readRegB),
        .data_readRegA(nbDataA), .data_readRegB(nbDataB),
        .ctrl_claimEnable(claimEnable), .ctrl_claimReg(claimReg),
        .busy_A(nbBusyA), .busy_B(nbBusyB), .claim_reject(nbReject), .busy_count(nbBusyCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [5:0] modelPopCount();
        logic [5:0] n = '0;
        for (int i = 0; i < 32; i++) begin
            if (mBusy[i]) n = n + 6'd1;
        end
        return n;
    endfunction

    // Drive one cycle, predict outputs from the model, then compare after the clock edge.
    task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [4:0] rb,
                                 input logic ce, input logic [4:0] cr, input logic rst);
        expT e;
        expT got;
        logic wPres, wAcc;
        @(negedge clock);
        writeEnable = we; writeReg = wr; writeData = wd;
        readRegA = ra; readRegB = rb;
        claimEnable = ce; claimReg = cr; ctrlReset = rst;

        wPres = we && (wr != 5'd0);
        wAcc  = wPres && rst;
        e.nA  = (ra == 5'd0) ? 32'd0 : mRegs[ra];
        e.nB  = (rb == 5'd0) ? 32'd0 : mRegs[rb];
        e.dA  = (wAcc && wr == ra) ? wd : e.nA;
        e.dB  = (wAcc && wr == rb) ? wd : e.nB;
        e.nbA = (ra != 5'd0) && mBusy[ra];
        e.nbB = (rb != 5'd0) && mBusy[rb];
        e.bA  = e.nbA && !(wAcc && wr == ra);
        e.bB  = e.nbB && !(wAcc && wr == rb);
        e.rej = ce && (cr != 5'd0) && mBusy[cr] && !(wPres && wr == cr);

        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (wAcc) begin
                mRegs[wr] = wd;
                mBusy[wr] = 1'b0;
            end
            if (ce && (cr != 5'd0) && !e.rej) mBusy[cr] = 1'b1;
        end
        e.cnt = modelPopCount();
        expQ.push_back(e);

        #1;
        got.dA = dataA;  got.dB = dataB;  got.nA = nbDataA;  got.nB = nbDataB;
        got.bA = busyA;  got.bB = busyB;  got.nbA = nbBusyA; got.nbB = nbBusyB;
        got.rej = reject;
        checkOutput("rejectNoBypass", 32'(nbReject), 32'(reject));

        @(posedge clock);
        #1;
        e = expQ.pop_front();
        checkOutput("dataA", got.dA, e.dA);
        checkOutput("dataB", got.dB, e.dB);
        checkOutput("dataA_nobyp", got.nA, e.nA);
        checkOutput("dataB_nobyp", got.nB, e.nB);
        checkOutput("busyA", 32'(got.bA), 32'(e.bA));
        checkOutput("busyB", 32'(got.bB), 32'(e.bB));
        checkOutput("busyA_nobyp", 32'(got.nbA), 32'(e.nbA));
        checkOutput("busyB_nobyp", 32'(got.nbB), 32'(e.nbB));
        checkOutput("claimReject", 32'(got.rej), 32'(e.rej));
        checkOutput("busyCount", 32'(busyCount), 32'(e.cnt));
        checkOutput("busyCount_nobyp", 32'(nbBusyCount), 32'(e.cnt));
    endtask

    task automatic readPair(input logic [4:0] ra, input logic [4:0] rb);
        applyStimulus(1'b0, 5'd0, 32'd0, ra, rb, 1'b0, 5'd0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ctrlReset = 1'b0; writeEnable = 1'b0; writeReg = '0; writeData = '0;
        readRegA = '0; readRegB = '0; claimEnable = 1'b0; claimReg = '0;
        repeat (2) @(posedge clock);
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = '0;
            mBusy[i] = 1'b0;
        end

        // Reset state across every index on both ports
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) readPair(5'(i), 5'(31 - i));

        // Basic write/read and hardwired zero register
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
        readPair(5'd7, 5'd0);
        applyStimulus(1'b1, 5'd0, 32'h00001234, 5'd0, 5'd7, 1'b0, 5'd0, 1'b1);
        readPair(5'd0, 5'd0);

        // Forwarding on one instance, pre-edge value on the other
        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 1'b0, 5'd0, 1'b1);
        readPair(5'd3, 5'd7);

        // Claim, duplicate claim, claim with retiring write, plain write
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        applyStimulus(1'b1, 5'd5, 32'h00000055, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        readPair(5'd5, 5'd0);
        applyStimulus(1'b1, 5'd5, 32'h00000066, 5'd5, 5'd5, 1'b0, 5'd0, 1'b1);
        readPair(5'd5, 5'd5);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);

        // Fill every claimable register, then retire and re-claim one together
        for (int i = 1; i < 32; i++) applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'd9, 1'b1, 5'(i), 1'b1);
        applyStimulus(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
        applyStimulus(1'b1, 5'd12, 32'h0000000C, 5'd12, 5'd9, 1'b1, 5'd20, 1'b1);

        // Reset wins over a concurrent write and claim
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd2, 32'h00000055, 5'd2, 5'd4, 1'b1, 5'd4, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1);
        applyStimulus(1'b1, 5'd2, 32'h00000077, 5'd2, 5'd6, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < 8; i++) readPair(5'(i), 5'(i + 1));

        // Mixed traffic
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 19) != 0));
        end

        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
